// File: rtl/io_pkg.sv
// io_pkg -- shared definitions for the bus packet encoder slice.
//   BUS_WIDTH      : width of one CPU_Bus beat
//   HDR_*          : header beat field positions and widths
//   enc_state_e    : encoder FSM state encoding
//   build_header() : assembles a header beat from its three fields
package io_pkg;

  localparam int unsigned BUS_WIDTH    = 32;
  localparam int unsigned HDR_FIELD_W  = 13;
  localparam int unsigned HDR_TYPE_W   = 3;
  localparam int unsigned HDR_TYPE_LSB = 29;
  localparam int unsigned HDR_WC_LSB   = 16;
  localparam int unsigned HDR_ADDR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE,
    ANNOUNCE,
    HEADER,
    FETCH,
    SEND_LO,
    SEND_HI,
    TRAILER,
    DONE
  } enc_state_e;

  // Bits [15:13] are reserved and always zero.
  function automatic logic [BUS_WIDTH-1:0] build_header(
    input logic [HDR_TYPE_W-1:0]  ptype,
    input logic [HDR_FIELD_W-1:0] wcount,
    input logic [HDR_FIELD_W-1:0] saddr
  );
    logic [BUS_WIDTH-1:0] h;
    h = '0;
    h[HDR_TYPE_LSB +: HDR_TYPE_W]  = ptype;
    h[HDR_WC_LSB   +: HDR_FIELD_W] = wcount;
    h[HDR_ADDR_LSB +: HDR_FIELD_W] = saddr;
    return h;
  endfunction

endpackage

// File: rtl/enc_parity_acc.sv
// enc_parity_acc -- running XOR of accepted payload beats.
//   clk_i    : clock, rising edge
//   rst_i    : asynchronous active-high reset, clears the accumulator
//   clr_i    : synchronous clear at the start of a packet
//   en_i     : a payload beat is accepted this cycle
//   data_i   : the beat being accepted
//   parity_o : XOR of all beats accepted since the last clear
module enc_parity_acc
  import io_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 en_i,
  input  logic [BUS_WIDTH-1:0] data_i,
  output logic [BUS_WIDTH-1:0] parity_o
);

  logic [BUS_WIDTH-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign parity_o = acc_q;

endmodule

// File: rtl/bus_packet_encoder.sv
// bus_packet_encoder -- reads Word_Count 64-bit words from a source memory and
// sends them over a 32-bit tri-state CPU bus as: header, then low/high half of
// each word, optionally followed by a parity trailer.
//   CLK, RST        : clock (rising edge), asynchronous active-high reset
//   Start           : one-cycle packet request, ignored while Busy
//   Packet_Type     : header type field
//   Start_Address   : destination address carried in the header
//   Word_Count      : number of 64-bit payload words (0 allowed)
//   Src_Address     : first source-memory word address
//   RAM_Address_RD  : source-memory read address
//   RAM_Data_RD     : source-memory read data, valid one cycle after address
//   CPU_Bus         : packet beats, high-Z when not driving
//   Bus_Ready       : receiver accepts the current beat this cycle
//   INT             : start-of-packet strobe (ANNOUNCE cycle)
//   Load_Process    : high from ANNOUNCE until the last beat is accepted
//   Busy            : session active (ANNOUNCE through DONE)
//   Done_Sending    : one-cycle completion pulse
// Build option: define ENCODER_PARITY_EN to append an XOR trailer beat.
module bus_packet_encoder
  import io_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = 13,
  parameter int unsigned DATA_WIDTH    = 64
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     Start,
  input  logic [2:0]               Packet_Type,
  input  logic [ADDRESS_WIDTH-1:0] Start_Address,
  input  logic [ADDRESS_WIDTH-1:0] Word_Count,
  input  logic [ADDRESS_WIDTH-1:0] Src_Address,
  output logic [ADDRESS_WIDTH-1:0] RAM_Address_RD,
  input  logic [DATA_WIDTH-1:0]    RAM_Data_RD,
  inout  wire  [BUS_WIDTH-1:0]     CPU_Bus,
  input  logic                     Bus_Ready,
  output logic                     INT,
  output logic                     Load_Process,
  output logic                     Busy,
  output logic                     Done_Sending
);

`ifdef ENCODER_PARITY_EN
  localparam enc_state_e AFTER_PAYLOAD = TRAILER;
`else
  localparam enc_state_e AFTER_PAYLOAD = DONE;
`endif

  enc_state_e               state_q, state_d;
  logic [2:0]               type_q, type_d;
  logic [ADDRESS_WIDTH-1:0] saddr_q, saddr_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    buf_q, buf_d;
  logic                     wait_q, wait_d;

  logic                     bus_en;
  logic [BUS_WIDTH-1:0]     bus_data;

`ifdef ENCODER_PARITY_EN
  logic                     par_clr;
  logic                     beat_acc;
  logic [BUS_WIDTH-1:0]     parity;

  enc_parity_acc u_parity (
    .clk_i    (CLK),
    .rst_i    (RST),
    .clr_i    (par_clr),
    .en_i     (beat_acc),
    .data_i   (bus_data),
    .parity_o (parity)
  );
`endif

  always_comb begin
    state_d  = state_q;
    type_d   = type_q;
    saddr_d  = saddr_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    buf_d    = buf_q;
    wait_d   = wait_q;
    bus_en   = 1'b0;
    bus_data = '0;
`ifdef ENCODER_PARITY_EN
    par_clr  = 1'b0;
    beat_acc = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (Start) begin
          type_d  = Packet_Type;
          saddr_d = Start_Address;
          cnt_d   = Word_Count;
          addr_d  = Src_Address;
          state_d = ANNOUNCE;
`ifdef ENCODER_PARITY_EN
          par_clr = 1'b1;
`endif
        end
      end
      ANNOUNCE: state_d = HEADER;
      HEADER: begin
        bus_en   = 1'b1;
        bus_data = build_header(type_q, HDR_FIELD_W'(cnt_q), HDR_FIELD_W'(saddr_q));
        if (Bus_Ready) begin
          wait_d  = 1'b0;
          state_d = (cnt_q == '0) ? AFTER_PAYLOAD : FETCH;
        end
      end
      // Two cycles: the first lets the memory register addr_q, the second
      // captures the returned word.
      FETCH: begin
        if (!wait_q) begin
          wait_d = 1'b1;
        end else begin
          wait_d  = 1'b0;
          buf_d   = RAM_Data_RD;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        bus_en   = 1'b1;
        bus_data = buf_q[0 +: BUS_WIDTH];
        if (Bus_Ready) begin
          state_d = SEND_HI;
`ifdef ENCODER_PARITY_EN
          beat_acc = 1'b1;
`endif
        end
      end
      SEND_HI: begin
        bus_en   = 1'b1;
        bus_data = buf_q[BUS_WIDTH +: BUS_WIDTH];
        if (Bus_Ready) begin
          cnt_d   = cnt_q - 1'b1;
          addr_d  = addr_q + 1'b1;
          state_d = (cnt_q == ADDRESS_WIDTH'(1)) ? AFTER_PAYLOAD : FETCH;
`ifdef ENCODER_PARITY_EN
          beat_acc = 1'b1;
`endif
        end
      end
`ifdef ENCODER_PARITY_EN
      TRAILER: begin
        bus_en   = 1'b1;
        bus_data = parity;
        if (Bus_Ready) begin
          state_d = DONE;
        end
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      type_q  <= '0;
      saddr_q <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      wait_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      saddr_q <= saddr_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      wait_q  <= wait_d;
    end
  end

  // Outputs decode registered state only, so an asynchronous reset clears
  // them (and releases the bus) in the same cycle.
  assign CPU_Bus        = bus_en ? bus_data : 'z;
  assign RAM_Address_RD = addr_q;
  assign INT            = (state_q == ANNOUNCE);
  assign Busy           = (state_q != IDLE);
  assign Done_Sending   = (state_q == DONE);
  assign Load_Process   = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: doc/bus_packet_encoder.md
BUS_PACKET_ENCODER -- requirements
Module: bus_packet_encoder

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 13, width of the source-memory address and of the packet start address.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, width of one payload word; fixed at 2x bus width.
REQ-003 SHALL have port CLK  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to send a packet.
REQ-006 SHALL have port Packet_Type  input  3  header type field, sampled on accepted Start.
REQ-007 SHALL have port Start_Address  input  ADDRESS_WIDTH  destination address carried in the header.
REQ-008 SHALL have port Word_Count  input  ADDRESS_WIDTH  number of 64-bit payload words, 0 legal.
REQ-009 SHALL have port Src_Address  input  ADDRESS_WIDTH  first source-memory address to read.
REQ-010 SHALL have port RAM_Address_RD  output  ADDRESS_WIDTH  source-memory read address.
REQ-011 SHALL have port RAM_Data_RD  input  DATA_WIDTH  read data, valid 1 cycle after address.
REQ-012 SHALL have port CPU_Bus  inout  32  packet beats; high-Z whenever not driving.
REQ-013 SHALL have port Bus_Ready  input  1  receiver accepts the current beat this cycle.
REQ-014 SHALL have port INT  output  1  start-of-packet strobe to the receiver.
REQ-015 SHALL have port Load_Process  output  1  high for the whole packet session.
REQ-016 SHALL have ports Busy and Done_Sending  output  1 each  session active / one-cycle completion pulse.

Function
REQ-017 SHALL use FSM states IDLE, ANNOUNCE, HEADER, FETCH, SEND_LO, SEND_HI, TRAILER, DONE.
REQ-018 SHALL in IDLE accept Start, latch all request inputs, go to ANNOUNCE; Start while Busy is ignored.
REQ-019 SHALL in ANNOUNCE assert INT and Load_Process for exactly one cycle, then go to HEADER.
REQ-020 SHALL drive header beat {Packet_Type[2:0], Word_Count[12:0] in [28:16], 3'b0, Start_Address[12:0]} zero-extended per field; header held until Bus_Ready.
REQ-021 SHALL after header go to DONE if Word_Count==0 (or TRAILER if enabled), else FETCH.
REQ-022 SHALL in FETCH present RAM_Address_RD and capture RAM_Data_RD into a 64-bit buffer one cycle later, then enter SEND_LO.
REQ-023 SHALL drive bits [31:0] in SEND_LO and [63:32] in SEND_HI; each beat held stable until Bus_Ready; one beat max per cycle.
REQ-024 SHALL after SEND_HI decrement remaining count, increment read address (wrap modulo 2^ADDRESS_WIDTH), return to FETCH or leave payload when count reaches 0.
REQ-025 SHALL hold Load_Process high from ANNOUNCE through last beat accepted; low in DONE.
REQ-026 SHALL pulse Done_Sending one cycle in DONE, then return to IDLE; Busy high from ANNOUNCE through DONE.
REQ-027 SHALL wait indefinitely with Bus_Ready low; no timeout.

Reset
REQ-028 SHALL on RST immediately release CPU_Bus to high-Z and clear INT, Load_Process, Busy, Done_Sending, RAM_Address_RD to 0, FSM to IDLE, counters and buffer to 0, including mid-packet.

Configuration
REQ-029 SHALL with ENCODER_PARITY_EN defined append a TRAILER beat equal to XOR of all payload beats (0 for empty payload), held until Bus_Ready.
REQ-030 SHALL with ENCODER_PARITY_EN undefined omit TRAILER and the accumulator entirely.

Structure
REQ-031 SHALL place BUS_WIDTH=32, header field positions, and the FSM state enum in shared package io_pkg.
REQ-032 SHALL implement parity as sub-module enc_parity_acc (clear, beat-accept enable, 32-bit data), instantiated only under ENCODER_PARITY_EN.

Verification
REQ-033 SHALL check: Start, type 3'b010, Start_Address 0x0040, Word_Count 0, Bus_Ready always 1 -> INT 1 cycle, header 0x4000_0040, Done_Sending 1 cycle later, bus Z.
REQ-034 SHALL check: Word_Count 2, RAM[5]=0x1111_2222_3333_4444, RAM[6]=0x5555_6666_7777_8888 -> beats header,0x3333_4444,0x1111_2222,0x7777_8888,0x5555_6666.
REQ-035 SHALL check: Bus_Ready low 10 cycles during SEND_HI -> beat unchanged, no extra RAM read.
REQ-036 SHALL check: Src_Address 0x1FFF, Word_Count 2 -> reads 0x1FFF then 0x0000.
REQ-037 SHALL check: RST asserted mid-SEND_LO -> same-cycle bus Z, outputs 0, next Start yields fresh header.
REQ-038 SHALL check with ENCODER_PARITY_EN: payloads of REQ-034 -> trailer 0x3333_4444^0x1111_2222^0x7777_8888^0x5555_6666.
